// File: rtl/lpc_sniffer.sv
// ---------------------------------------------------------------------------
// lpc_sniffer
//
// Passive LPC bus monitor. Samples LAD[3:0] and LFRAME# on the rising edge
// of the LPC clock and decodes single-byte I/O and memory read/write cycles.
// Each completed cycle is presented on parallel outputs together with a
// one-cycle strobe. The block only observes the bus and never drives it.
//
// Ports:
//   lpc_clock        in   1   LPC clock, all sampling on its rising edge
//   lpc_reset        in   1   asynchronous, active-high reset
//   lpc_ad           in   4   LAD[3:0]
//   lpc_frame        in   1   LFRAME#, active low
//   out_cyctype_dir  out  4   cycle-type/direction nibble as sampled
//                             ([3:2] 00 I/O, 01 memory; [1] 0 read, 1 write)
//   out_addr         out  32  captured address, zero-extended
//   out_data         out  32  captured data byte in [7:0], upper bits zero
//   out_data_size    out  4   number of data bytes captured (always 1)
//   out_clock_enable out  1   one-cycle strobe, outputs hold a new transaction
// ---------------------------------------------------------------------------
module lpc_sniffer (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  lpc_ad,
    input  logic        lpc_frame,
    output logic [3:0]  out_cyctype_dir,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [3:0]  out_data_size,
    output logic        out_clock_enable
);

    typedef enum logic [2:0] {
        IDLE,
        CYCTYPE,
        ADDR,
        TAR1,
        SYNC,
        DATA,
        TAR2
    } state_t;

    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [2:0]  cnt_next;
    logic [3:0]  cyctype;
    logic [31:0] addr;
    logic [7:0]  data;

    logic        is_write;
    logic [2:0]  last_addr_nibble;
    logic        done;
    logic [7:0]  data_final;

    assign is_write         = cyctype[1];
    // Memory cycles carry 8 address nibbles, I/O cycles carry 4.
    assign last_addr_nibble = cyctype[2] ? 3'd7 : 3'd3;
    // A read completes on the high data nibble, which is still on the bus;
    // a write already holds both nibbles by the time SYNC reports ready.
    assign data_final       = is_write ? data : {lpc_ad, data[3:0]};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        done       = 1'b0;

        if (!lpc_frame) begin
            // LFRAME# low overrides everything: either a fresh START or a
            // return to idle. Holding it low simply re-evaluates each cycle,
            // so the last low cycle is the one that defines START.
            state_next = (lpc_ad == 4'b0000) ? CYCTYPE : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                CYCTYPE: begin
                    // Type 1x is DMA/reserved and is not decoded.
                    state_next = lpc_ad[3] ? IDLE : ADDR;
                end
                ADDR: begin
                    if (cnt == last_addr_nibble) begin
                        state_next = is_write ? DATA : TAR1;
                    end
                end
                TAR1: begin
                    if (cnt == 3'd1) begin
                        state_next = SYNC;
                    end
                end
                SYNC: begin
                    if (lpc_ad == SYNC_READY) begin
                        if (is_write) begin
                            done       = 1'b1;
                            state_next = TAR2;
                        end else begin
                            state_next = DATA;
                        end
                    end else if (lpc_ad == SYNC_SHORT_WAIT ||
                                 lpc_ad == SYNC_LONG_WAIT) begin
                        state_next = SYNC;
                    end else begin
                        state_next = IDLE;
                    end
                end
                DATA: begin
                    if (cnt == 3'd1) begin
                        if (is_write) begin
                            state_next = TAR1;
                        end else begin
                            done       = 1'b1;
                            state_next = TAR2;
                        end
                    end
                end
                TAR2: begin
                    if (cnt == 3'd1) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // The phase counter restarts on every state change and counts
        // cycles spent in the current phase otherwise.
        cnt_next = (state_next == state) ? cnt + 3'd1 : 3'd0;
    end

    // -----------------------------------------------------------------------
    // State register and capture datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            cyctype <= 4'd0;
            addr    <= 32'd0;
            data    <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state <= state_next;
            cnt   <= cnt_next;

            if (lpc_frame) begin
                unique case (state)
                    CYCTYPE: begin
                        cyctype <= lpc_ad;
                        // Clearing here makes I/O addresses zero-extended.
                        addr    <= 32'd0;
                    end
                    ADDR: begin
                        addr <= {addr[27:0], lpc_ad};
                    end
                    DATA: begin
                        if (cnt == 3'd0) begin
                            data[3:0] <= lpc_ad;
                        end else begin
                            data[7:4] <= lpc_ad;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output registers: loaded on the edge that captures the final element,
    // held until the next completed transaction.
    // -----------------------------------------------------------------------
    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            out_cyctype_dir  <= 4'd0;
            out_addr         <= 32'd0;
            out_data         <= 32'd0;
            out_data_size    <= 4'd0;
            out_clock_enable <= 1'b0;
        end else begin
            out_clock_enable <= done;
            if (done) begin
                out_cyctype_dir <= cyctype;
                out_addr        <= addr;
                out_data        <= {24'd0, data_final};
                out_data_size   <= 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_lpc_sniffer.sv
// ---------------------------------------------------------------------------
// tb_lpc_sniffer
//
// Directed testbench for lpc_sniffer. Drives LPC nibble sequences on the
// falling clock edge, counts strobes on the falling edge and compares the
// captured outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_lpc_sniffer;

    logic        lpc_clock;
    logic        lpc_reset;
    logic [3:0]  lpc_ad;
    logic        lpc_frame;
    logic [3:0]  out_cyctype_dir;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_data_size;
    logic        out_clock_enable;

    int total = 0;
    int bad   = 0;
    int strobes = 0;

    lpc_sniffer dut (
        .lpc_clock        (lpc_clock),
        .lpc_reset        (lpc_reset),
        .lpc_ad           (lpc_ad),
        .lpc_frame        (lpc_frame),
        .out_cyctype_dir  (out_cyctype_dir),
        .out_addr         (out_addr),
        .out_data         (out_data),
        .out_data_size    (out_data_size),
        .out_clock_enable (out_clock_enable)
    );

    initial lpc_clock = 1'b0;
    always #5 lpc_clock = ~lpc_clock;

    // Each strobe cycle is seen at exactly one falling edge.
    always @(negedge lpc_clock) begin
        if (out_clock_enable === 1'b1) strobes++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [3:0] a);
        @(negedge lpc_clock);
        lpc_frame = f;
        lpc_ad    = a;
    endtask

    // Full transaction: START, cycle type, address, then the read or write
    // tail with optional SYNC wait states and a selectable final SYNC value.
    task automatic xfer(input logic [3:0] ct, input logic [31:0] addr,
                        input logic [7:0] data, input int waits,
                        input logic [3:0] sync_final);
        int nibs;
        int s0;
        s0   = strobes;
        nibs = ct[2] ? 8 : 4;
        drive(1'b0, 4'h0);
        drive(1'b1, ct);
        for (int i = nibs - 1; i >= 0; i--) drive(1'b1, addr[i*4 +: 4]);
        if (ct[1]) begin
            drive(1'b1, data[3:0]);
            drive(1'b1, data[7:4]);
        end
        drive(1'b1, 4'hf);
        drive(1'b1, 4'hf);
        for (int i = 0; i < waits; i++) drive(1'b1, 4'h6);
        if (waits > 0) check("no_strobe_while_sync_wait", strobes, s0);
        drive(1'b1, sync_final);
        if (!ct[1]) begin
            drive(1'b1, data[3:0]);
            drive(1'b1, data[7:4]);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 4'hf);
    endtask

    task automatic check_result(input string name, input int s0,
                                input logic [3:0] ct, input logic [31:0] addr,
                                input logic [31:0] data);
        check({name, ".strobes"}, strobes - s0, 1);
        check({name, ".cyctype_dir"}, {28'd0, out_cyctype_dir}, {28'd0, ct});
        check({name, ".addr"}, out_addr, addr);
        check({name, ".data"}, out_data, data);
        check({name, ".size"}, {28'd0, out_data_size}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        lpc_reset = 1'b1;
        lpc_frame = 1'b1;
        lpc_ad    = 4'hf;
        repeat (3) @(negedge lpc_clock);
        check("reset.strobe", {31'd0, out_clock_enable}, 32'd0);
        check("reset.cyctype_dir", {28'd0, out_cyctype_dir}, 32'd0);
        check("reset.addr", out_addr, 32'd0);
        check("reset.data", out_data, 32'd0);
        check("reset.size", {28'd0, out_data_size}, 32'd0);
        lpc_reset = 1'b0;
        repeat (2) @(negedge lpc_clock);

        // I/O read 0x7fe5 -> 0x6c
        s0 = strobes;
        xfer(4'h0, 32'h0000_7fe5, 8'h6c, 0, 4'h0);
        check_result("io_read", s0, 4'h0, 32'h0000_7fe5, 32'h0000_006c);

        // I/O write 0x0080 <- 0xa5
        s0 = strobes;
        xfer(4'h2, 32'h0000_0080, 8'ha5, 0, 4'h0);
        check_result("io_write", s0, 4'h2, 32'h0000_0080, 32'h0000_00a5);

        // Memory read with three long-wait SYNCs
        s0 = strobes;
        xfer(4'h4, 32'hffff_fff0, 8'h3c, 3, 4'h0);
        check_result("mem_read", s0, 4'h4, 32'hffff_fff0, 32'h0000_003c);

        // SYNC error drops the cycle; outputs keep the memory read values
        s0 = strobes;
        xfer(4'h0, 32'h0000_1234, 8'h99, 0, 4'ha);
        check("sync_err.strobes", strobes - s0, 0);
        check("sync_err.addr_held", out_addr, 32'hffff_fff0);
        s0 = strobes;
        xfer(4'h0, 32'h0000_002e, 8'h11, 0, 4'h0);
        check_result("after_sync_err", s0, 4'h0, 32'h0000_002e, 32'h0000_0011);

        // Abort during the address phase by a new START
        s0 = strobes;
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h9);
        drive(1'b1, 4'h9);
        xfer(4'h0, 32'h0000_0060, 8'h42, 0, 4'h0);
        check_result("abort", s0, 4'h0, 32'h0000_0060, 32'h0000_0042);

        // Type 1x is ignored
        s0 = strobes;
        xfer(4'h8, 32'h0000_5555, 8'h77, 0, 4'h0);
        check("dma_type.strobes", strobes - s0, 0);

        // Reset in the middle of the data phase
        s0 = strobes;
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h3);
        drive(1'b1, 4'hf);
        drive(1'b1, 4'h8);
        drive(1'b1, 4'hf);
        drive(1'b1, 4'hf);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h7);
        #2 lpc_reset = 1'b1;
        #1;
        check("mid_reset.addr", out_addr, 32'd0);
        check("mid_reset.data", out_data, 32'd0);
        check("mid_reset.cyctype_dir", {28'd0, out_cyctype_dir}, 32'd0);
        check("mid_reset.size", {28'd0, out_data_size}, 32'd0);
        drive(1'b1, 4'h1);
        lpc_reset = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 4'hf);
        check("mid_reset.strobes", strobes - s0, 0);
        s0 = strobes;
        xfer(4'h2, 32'h0000_03f8, 8'h55, 0, 4'h0);
        check_result("after_reset", s0, 4'h2, 32'h0000_03f8, 32'h0000_0055);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
